// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for a multicycle MIPS datapath.
//
// The FSM steps each instruction through fetch, decode, execute, memory and
// write-back. Every datapath control is decoded from the registered state.
// The only exceptions are ir_write and pc_write in IF, which also follow
// mem_ready, so the IR and PC load on the cycle the fetch completes.
//
// Build option:
//   IMM_ALU_EN  When defined, addi/andi/ori (0x08/0x0C/0x0D) run through
//               EXI -> WBI. When undefined, those opcodes are illegal and
//               encodings 11/12 behave like the other unused encodings.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   opcode          IR[31:26] of the current instruction
//   mem_ready       memory finished the current read/write this cycle
//   alusrca         0 = PC, 1 = rs data
//   alusrcb         00 rt, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2
//   alu_op          00 add, 01 sub, 10 funct-decoded, 11 imm-op decoded
//   pc_write        unconditional PC load
//   pc_write_cond   PC load if ALU zero
//   pc_source       00 ALU result, 01 ALUOut, 10 jump target
//   iord            0 = PC addresses memory, 1 = ALUOut
//   mem_read        memory read strobe
//   mem_write       memory write strobe
//   ir_write        IR load
//   reg_write       register file write
//   reg_dst         0 = rt, 1 = rd
//   mem_to_reg      0 = ALUOut, 1 = MDR
//   illegal_op      one-cycle flag, raised in ID for an unsupported opcode
//   state           current state encoding, for debug
module multicycle_ctrl #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               alusrca,
  output logic [1:0]         alusrcb,
  output logic [1:0]         alu_op,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic [1:0]         pc_source,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               illegal_op,
  output logic [STATE_W-1:0] state
);

  typedef enum logic [3:0] {
    StRst   = 4'd0,
    StIf    = 4'd1,
    StId    = 4'd2,
    StMaddr = 4'd3,
    StMrd   = 4'd4,
    StMwb   = 4'd5,
    StMwr   = 4'd6,
    StExr   = 4'd7,
    StWbr   = 4'd8,
    StBeq   = 4'd9,
    StJmp   = 4'd10,
    StExi   = 4'd11,
    StWbi   = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  state_e state_q, state_d;

  // Reset acts on the state register only. All outputs are state decodes, so
  // they drop to zero as soon as rst rises, and no write strobe can follow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StRst;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = StIf;
    alusrca       = 1'b0;
    alusrcb       = 2'b00;
    alu_op        = 2'b00;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_op    = 1'b0;

    case (state_q)
      StRst: begin
        state_d = StIf;
      end

      // Fetch: PC + 4 is computed in the ALU. IR and PC load only on the
      // cycle memory delivers the word.
      StIf: begin
        mem_read = 1'b1;
        alusrcb  = 2'b01;
        ir_write = mem_ready;
        pc_write = mem_ready;
        state_d  = mem_ready ? StId : StIf;
      end

      // Decode: the branch target (PC + imm<<2) is precomputed into ALUOut.
      StId: begin
        alusrcb = 2'b11;
        case (opcode)
          OpLw, OpSw: state_d = StMaddr;
          OpRtype:    state_d = StExr;
          OpBeq:      state_d = StBeq;
          OpJ:        state_d = StJmp;
`ifdef IMM_ALU_EN
          OpAddi, OpAndi, OpOri: state_d = StExi;
`endif
          default: begin
            illegal_op = 1'b1;
            state_d    = StIf;
          end
        endcase
      end

      StMaddr: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (opcode == OpLw) begin
          state_d = StMrd;
        end else if (opcode == OpSw) begin
          state_d = StMwr;
        end else begin
          // The opcode changed under us; abandon the instruction.
          state_d = StIf;
        end
      end

      StMrd: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        state_d  = mem_ready ? StMwb : StMrd;
      end

      StMwb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = StIf;
      end

      StMwr: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = mem_ready ? StIf : StMwr;
      end

      StExr: begin
        alusrca = 1'b1;
        alu_op  = 2'b10;
        state_d = StWbr;
      end

      StWbr: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = StIf;
      end

      StBeq: begin
        alusrca       = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        state_d       = StIf;
      end

      StJmp: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        state_d   = StIf;
      end

`ifdef IMM_ALU_EN
      StExi: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        alu_op  = 2'b11;
        state_d = StWbi;
      end

      StWbi: begin
        reg_write = 1'b1;
        state_d   = StIf;
      end
`endif

      // Unused encodings: outputs stay zero and the FSM returns to IF.
      default: begin
        state_d = StIf;
      end
    endcase
  end

  assign state = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl. The stimulus tasks walk each instruction
// through its expected state sequence. Every driven cycle pushes the
// expected output vector into a queue. A negedge monitor pops each entry
// and compares it with the DUT outputs.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b0;

  logic       alusrca, pc_write, pc_write_cond, iord, mem_read, mem_write;
  logic       ir_write, reg_write, reg_dst, mem_to_reg, illegal_op;
  logic [1:0] alusrcb, alu_op, pc_source;
  logic [3:0] state;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [20:0] exp_q[$];
  logic [20:0] got_vec;

  multicycle_ctrl #(.STATE_W(4)) u_dut (
    .clk           (clk),
    .rst           (rst),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .alusrca       (alusrca),
    .alusrcb       (alusrcb),
    .alu_op        (alu_op),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .illegal_op    (illegal_op),
    .state         (state)
  );

  always #5 clk = ~clk;

  assign got_vec = {state, alusrca, alusrcb, alu_op, pc_write, pc_write_cond, pc_source, iord,
                    mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, illegal_op};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected outputs for one cycle in state st.
  function automatic logic [20:0] exp_vec(input int st, input logic rdy, input logic [5:0] op);
    logic       a, pcw, pcwc, io, mr, mw, irw, rw, rd, m2r, ill;
    logic [1:0] srcb, aop, psrc;
    logic       legal;
    {a, pcw, pcwc, io, mr, mw, irw, rw, rd, m2r, ill} = '0;
    srcb = 2'b00;
    aop  = 2'b00;
    psrc = 2'b00;
    case (st)
      1:  begin mr = 1'b1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      2:  begin
        srcb  = 2'b11;
        legal = (op == 6'h23) || (op == 6'h2B) || (op == 6'h00) || (op == 6'h04) ||
                (op == 6'h02);
`ifdef IMM_ALU_EN
        legal = legal || (op == 6'h08) || (op == 6'h0C) || (op == 6'h0D);
`endif
        ill = !legal;
      end
      3:  begin a = 1'b1; srcb = 2'b10; end
      4:  begin mr = 1'b1; io = 1'b1; end
      5:  begin rw = 1'b1; m2r = 1'b1; end
      6:  begin mw = 1'b1; io = 1'b1; end
      7:  begin a = 1'b1; aop = 2'b10; end
      8:  begin rw = 1'b1; rd = 1'b1; end
      9:  begin a = 1'b1; aop = 2'b01; pcwc = 1'b1; psrc = 2'b01; end
      10: begin pcw = 1'b1; psrc = 2'b10; end
      11: begin a = 1'b1; srcb = 2'b10; aop = 2'b11; end
      12: begin rw = 1'b1; end
      default: ;
    endcase
    return {4'(st), a, srcb, aop, pcw, pcwc, psrc, io, mr, mw, irw, rw, rd, m2r, ill};
  endfunction

  // Called at posedge+1. Drives inputs, queues the expectation for this cycle
  // and returns at the next posedge+1.
  task automatic cyc(input int st, input logic rdy, input logic [5:0] op);
    mem_ready = rdy;
    opcode    = op;
    exp_q.push_back(exp_vec(st, rdy, op));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      check($sformatf("st%0d", state), 32'(got_vec), 32'(exp_q.pop_front()));
      check("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
      check("pcw_excl", 32'(pc_write & pc_write_cond), 32'd0);
    end
  end

  initial begin
    #1;
    check("rst_init", 32'(got_vec), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(0, 1'b0, 6'h00);

    // lw, no waits: 1,2,3,4,5
    cyc(1, 1'b1, 6'h23); cyc(2, 1'b1, 6'h23); cyc(3, 1'b1, 6'h23);
    cyc(4, 1'b1, 6'h23); cyc(5, 1'b1, 6'h23);
    // sw, three wait cycles in MWR
    cyc(1, 1'b1, 6'h2B); cyc(2, 1'b1, 6'h2B); cyc(3, 1'b1, 6'h2B);
    for (int i = 0; i < 3; i++) cyc(6, 1'b0, 6'h2B);
    cyc(6, 1'b1, 6'h2B);
    // R-type
    cyc(1, 1'b1, 6'h00); cyc(2, 1'b1, 6'h00); cyc(7, 1'b1, 6'h00); cyc(8, 1'b1, 6'h00);
    // beq then j
    cyc(1, 1'b1, 6'h04); cyc(2, 1'b1, 6'h04); cyc(9, 1'b1, 6'h04);
    cyc(1, 1'b1, 6'h02); cyc(2, 1'b1, 6'h02); cyc(10, 1'b1, 6'h02);
    // addi
    cyc(1, 1'b1, 6'h08); cyc(2, 1'b1, 6'h08);
`ifdef IMM_ALU_EN
    cyc(11, 1'b1, 6'h08); cyc(12, 1'b1, 6'h08);
`endif
    // illegal in both builds
    cyc(1, 1'b1, 6'h3F); cyc(2, 1'b1, 6'h3F);
    // ori with two fetch wait cycles
    cyc(1, 1'b0, 6'h0D); cyc(1, 1'b0, 6'h0D); cyc(1, 1'b1, 6'h0D); cyc(2, 1'b1, 6'h0D);
`ifdef IMM_ALU_EN
    cyc(11, 1'b0, 6'h0D); cyc(12, 1'b0, 6'h0D);
`endif
    // lw with one wait cycle in MRD
    cyc(1, 1'b1, 6'h23); cyc(2, 1'b1, 6'h23); cyc(3, 1'b1, 6'h23);
    cyc(4, 1'b0, 6'h23); cyc(4, 1'b1, 6'h23); cyc(5, 1'b1, 6'h23);

    // lw interrupted by reset mid-cycle in MRD
    cyc(1, 1'b1, 6'h23); cyc(2, 1'b1, 6'h23); cyc(3, 1'b1, 6'h23);
    mem_ready = 1'b0;
    #2;
    check("mrd_pre_rst", 32'(got_vec), 32'(exp_vec(4, 1'b0, 6'h23)));
    rst = 1'b1;
    #1;
    check("rst_async_outs", 32'(got_vec), 32'd0);
    check("rst_async_state", 32'(state), 32'd0);
    @(posedge clk);
    #1;
    check("rst_held", 32'(got_vec), 32'd0);
    rst = 1'b0;
    cyc(0, 1'b1, 6'h23);
    cyc(1, 1'b1, 6'h23);
    cyc(2, 1'b1, 6'h23);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Moore control FSM for the multicycle MIPS datapath. Sequences instruction fetch, decode, execute, memory and write-back. Drives the 2-bit ALU-B source select, ALU-A select, PC/IR/register/memory enables and the PC source mux. It sits beside the datapath and consumes only the IR opcode field and a memory-ready handshake.

Parameters:
STATE_W, 4, width of the state register and of the state debug port.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
opcode  in  6  IR[31:26] of the current instruction
mem_ready  in  1  memory has completed the current read/write this cycle
alusrca  out  1  0 = PC, 1 = rs data
alusrcb  out  2  00 = rt data, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
alu_op  out  2  00 add, 01 sub, 10 funct-decoded, 11 imm-op decoded
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero
pc_source  out  2  00 ALU result, 01 ALUOut register, 10 jump target
iord  out  1  0 = PC addresses memory, 1 = ALUOut
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
ir_write  out  1  IR load
reg_write  out  1  register file write
reg_dst  out  1  0 = rt, 1 = rd
mem_to_reg  out  1  0 = ALUOut, 1 = MDR
illegal_op  out  1  one-cycle flag, unsupported opcode
state  out  STATE_W  current state, debug

Behaviour:
- Single clock domain. rst asynchronous, active-high: state forced to RST immediately, independent of clk.
- All outputs are combinational decodes of the registered state, plus mem_ready where noted. Any output not listed for a state is 0.
- State encodings and output decodes:
  - RST=0: all outputs 0. Goes to IF on the first clock with rst low.
  - IF=1: mem_read=1, iord=0, alusrca=0, alusrcb=01, alu_op=00, pc_source=00. ir_write and pc_write equal mem_ready. Stays in IF while mem_ready=0; goes to ID when it is 1.
  - ID=2: alusrca=0, alusrcb=11, alu_op=00 (branch target into ALUOut). Next state by opcode:
    - 0x23 or 0x2B -> MADDR
    - 0x00 -> EXR
    - 0x04 -> BEQ
    - 0x02 -> JMP
    - 0x08/0x0C/0x0D -> see optional feature
    - any other -> IF with illegal_op=1 during this ID cycle only
  - MADDR=3: alusrca=1, alusrcb=10, alu_op=00. opcode 0x23 -> MRD, 0x2B -> MWR.
  - MRD=4: mem_read=1, iord=1. Waits on mem_ready, then goes to MWB.
  - MWB=5: reg_write=1, mem_to_reg=1, reg_dst=0. Then IF.
  - MWR=6: mem_write=1, iord=1. Waits on mem_ready, then goes to IF.
  - EXR=7: alusrca=1, alusrcb=00, alu_op=10. Then WBR.
  - WBR=8: reg_write=1, reg_dst=1, mem_to_reg=0. Then IF.
  - BEQ=9: alusrca=1, alusrcb=00, alu_op=01, pc_write_cond=1, pc_source=01. Then IF.
  - JMP=10: pc_write=1, pc_source=10. Then IF.
  - EXI=11: alusrca=1, alusrcb=10, alu_op=11. Then WBI.
  - WBI=12: reg_write=1, reg_dst=0, mem_to_reg=0. Then IF.
  - Unused encodings 13-15 go to IF with all outputs 0.
- Latency with mem_ready tied 1:
  - lw 5 cycles
  - sw, R-type, imm 4 cycles
  - beq, j 3 cycles
- Each mem_ready=0 cycle in IF, MRD or MWR adds exactly one cycle. Strobes are held constant while waiting.
- mem_write and mem_read are never asserted together. pc_write and pc_write_cond are never asserted together.
- rst asserted mid-instruction: all outputs drop to 0 asynchronously. No partial reg_write or mem_write may occur after the rst edge.

Optional Feature:
IMM_ALU_EN
- Defined: ID with opcode 0x08 (addi), 0x0C (andi) or 0x0D (ori) goes to EXI, then WBI, then IF.
- Not defined: EXI/WBI logic is absent. Those opcodes take the illegal path (illegal_op=1, return to IF), and encodings 11/12 behave as unused.

Test Plan:
- Assert rst mid-cycle in MRD -> all outputs 0 at once, state=0. After release: RST, then IF with mem_read=1, alusrcb=01.
- opcode 0x23, mem_ready=1 -> states 1,2,3,4,5. alusrcb sequence 01,11,10,00,00. reg_write=1 and mem_to_reg=1 only in cycle 5.
- opcode 0x2B, mem_ready low for 3 cycles in MWR -> mem_write=1 and iord=1 held for 4 cycles, then IF. reg_write never asserted.
- opcode 0x00 -> states 1,2,7,8. In EXR: alusrcb=00, alu_op=10. In WBR: reg_write=1, reg_dst=1.
- opcode 0x04, then 0x02 -> beq: pc_write_cond=1, pc_source=01, alu_op=01 in state 9. j: pc_write=1, pc_source=10 in state 10. Each 3 cycles.
- opcode 0x08 -> with IMM_ALU_EN: states 1,2,11,12, alusrcb=10, alu_op=11. Without it: illegal_op=1 in ID, next state IF. Opcode 0x3F -> illegal_op=1 in either build.
